pwm_ramp_sequencer: RTL and testbench
=====================================

# pwm_ramp_sequencer

Sequencer that drives the write port of the GPIO/duty register, so the PWM duty ramps up, holds, and ramps down without a host write on every step. It sits between the host write path (`ui_in` data, `uio_in[0]` strobe) and the duty register's `we`/`wdata` inputs. It also shares that single write port between the host and itself, with the host always winning a collision. All state is sequential: a prescaler, a ramp FSM, a hold counter, and a deferred-write flag.

## Interface
Parameters:
- `PRESC_W`, default 16: width of the tick prescaler and of `tick_div`.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: global enable; low freezes all state and blocks every write.
- `host_we` in 1: host write strobe.
- `host_wdata` in 8: host write data.
- `start` in 1: begin a ramp; sampled in IDLE only.
- `stop` in 1: abort to IDLE.
- `loop` in 1: at the end of DOWN, restart UP instead of going to IDLE.
- `step` in 4: duty increment/decrement per tick; 0 is treated as 1.
- `hold_ticks` in 8: HOLD lasts `hold_ticks`+1 ticks.
- `tick_div` in PRESC_W: one tick every `tick_div`+1 cycles.
- `reg_we` out 1: write strobe to the duty register.
- `reg_wdata` out 8: write data to the duty register.
- `busy` out 1: high when state is not IDLE.
- `state` out 2: IDLE=0, UP=1, HOLD=2, DOWN=3.
- `done` out 1: one-cycle pulse on a natural return to IDLE.

## Operation
- Internal registers:
  - `duty` (8b), `pend` (1b), `hold_cnt` (8b), `presc` (PRESC_W).
  - Shadow registers `step_s`, `hold_s`, `div_s`, loaded on accepted `start`. Input changes mid-run are ignored.
- Write port:
  - `reg_we = ena & (host_we | pend)`.
  - `reg_wdata = host_we ? host_wdata : duty`.
  - `pend` clears on any cycle with `ena & pend & !host_we`.
  - While `host_we` stays high, `pend` holds. Multiple duty updates coalesce, and the latest `duty` is written.
- Tick:
  - `presc` counts 0..`div_s` while not IDLE and `ena`=1.
  - The tick is high in the cycle where `presc == div_s`; `presc` wraps to 0 at that point.
  - `presc` is cleared on accepted `start` and on every entry to UP.
- IDLE:
  - `start & !stop & ena` loads the shadows, sets `duty`=0 and `pend`=1, and moves to UP.
  - `start` in any other state is ignored.
- UP, on tick:
  - Compute a 9-bit sum `duty + step_s`.
  - If the sum ≥ 255: `duty`=255, `hold_cnt`=`hold_s`, move to HOLD.
  - Otherwise `duty` += `step_s`.
  - `pend`=1 in both cases.
- HOLD, on tick:
  - If `hold_cnt`==0, move to DOWN; otherwise decrement `hold_cnt`.
  - No write is issued.
- DOWN, on tick, with `pend`=1:
  - If `duty` ≤ `step_s`: `duty`=0. Then, if `loop`, move to UP. Otherwise move to IDLE and pulse `done`.
  - Otherwise `duty` -= `step_s`.
  - No wrap-around below 0 or above 255, ever.
- `stop`:
  - In any non-IDLE state: next state IDLE, `duty`=0, `pend`=1, no `done`.
  - `stop` beats `start` and any same-cycle tick.
  - `stop` in IDLE has no effect.
- `ena`=0: no state, counter, or `pend` change, and `reg_we`=0. The host write is dropped, not queued.

## Timing
- Reset (async, while `rst_n` low):
  - state IDLE, `duty`=0, `pend`=0, `presc`=0, `hold_cnt`=0, shadows 0.
  - Outputs: `busy`=0, `done`=0, `state`=0, `reg_we`=`host_we & ena`, `reg_wdata`=`host_we ? host_wdata : 0`.
- Reset asserted mid-ramp: immediate return to reset values. The register write of 0 is not issued; the duty register has its own reset.
- `start` sampled at edge N:
  - `state`=UP and `busy`=1 from N+1.
  - `reg_we` with data 0 in cycle N+1, provided `host_we`=0.
- First tick: in cycle N+1+`div_s`.
- Per-update latency: a tick in cycle T updates `duty` at the end of T, and the write appears in cycle T+1 unless the host holds the port.
- `done`: high for exactly the cycle after the final DOWN tick, coincident with `state`=IDLE and the write of 0.
- `host_we`: combinational to `reg_we`/`reg_wdata` with zero latency. Every other output is registered.

## Test plan
- Full ramp: `step`=4'd0 (treated as 1), `tick_div`=0, `hold_ticks`=0, `start` pulse.
  - Expected writes: 0, 1, …, 255, then 254 … 0.
  - `done` fires once; `busy` falls in the same cycle.
- Coarse ramp: `step`=8, `tick_div`=3, `hold_ticks`=2.
  - Ticks every 4 cycles; writes 0, 8, 16 … 248, 255; HOLD spans 3 ticks (12 cycles).
  - Down writes 247 … 7, then 0.
- Collision:
  - Assert `host_we`=1 with `host_wdata`=8'hA5 in the cycle a sequencer write is due → `reg_wdata`=A5.
  - Hold `host_we` for 3 cycles spanning a second tick → a single coalesced write of the latest `duty` in the first free cycle.
- Abort: `stop` during HOLD → `state`=0 next cycle, one write of 0, `done` stays 0. `start`+`stop` in the same IDLE cycle → stays IDLE.
- Loop and enable:
  - `loop`=1, `step`=15 → after 15 reaches 0, UP restarts with no `done`.
  - Drop `ena` for 5 cycles mid-UP → `state`, `duty` and `presc` are frozen, `reg_we`=0 even with `host_we`=1; the sequence resumes exactly where it stopped.
- Reset: `rst_n` low asynchronously (between edges) mid-DOWN → all outputs reach their reset values immediately. A new `start` after release begins again from 0.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// Duty-register write sequencer: ramps a PWM duty 0 -> 255, holds, ramps back to 0,
// sharing the register's single write port with the host (host always wins).
module pwm_ramp_sequencer #(
   parameter int PRESC_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               host_we,
   input  logic [7:0]         host_wdata,
   input  logic               start,
   input  logic               stop,
   input  logic               loop,
   input  logic [3:0]         step,
   input  logic [7:0]         hold_ticks,
   input  logic [PRESC_W-1:0] tick_div,
   output logic               reg_we,
   output logic [7:0]         reg_wdata,
   output logic               busy,
   output logic [1:0]         state,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_HOLD = 2'd2,
      S_DOWN = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [7:0]           duty_q, duty_d;
   logic                 pend_q, pend_d;
   logic [7:0]           hold_cnt_q, hold_cnt_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [3:0]           step_s_q, step_s_d;
   logic [7:0]           hold_s_q, hold_s_d;
   logic [PRESC_W-1:0]   div_s_q, div_s_d;
   logic                 done_q, done_d;
   logic                 tick;
   logic [8:0]           up_sum;

   // Write port: a write is presented whenever reg_we is high; the register
   // accepts it that cycle (no back-pressure). pend marks a sequencer write that
   // is owed; it survives host-occupied cycles and always carries the latest duty.
   assign reg_we    = ena & (host_we | pend_q);
   assign reg_wdata = host_we ? host_wdata : duty_q;
   assign busy      = (state_q != S_IDLE);
   assign state     = state_q;
   assign done      = done_q;

   assign tick   = (state_q != S_IDLE) && (presc_q == div_s_q);
   assign up_sum = {1'b0, duty_q} + {5'b0, step_s_q};

   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      pend_d     = pend_q;
      hold_cnt_d = hold_cnt_q;
      presc_d    = presc_q;
      step_s_d   = step_s_q;
      hold_s_d   = hold_s_q;
      div_s_d    = div_s_q;
      done_d     = done_q;
      if (ena) begin
         done_d = 1'b0;
         if (!host_we) pend_d = 1'b0;
         if (state_q != S_IDLE)
            presc_d = tick ? '0 : presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
         case (state_q)
            S_IDLE: begin
               if (start && !stop) begin
                  step_s_d = (step == 4'd0) ? 4'd1 : step;
                  hold_s_d = hold_ticks;
                  div_s_d  = tick_div;
                  duty_d   = 8'd0;
                  pend_d   = 1'b1;
                  presc_d  = '0;
                  state_d  = S_UP;
               end
            end
            S_UP: begin
               if (tick) begin
                  pend_d = 1'b1;
                  if (up_sum >= 9'd255) begin
                     duty_d     = 8'd255;
                     hold_cnt_d = hold_s_q;
                     state_d    = S_HOLD;
                  end else begin
                     duty_d = up_sum[7:0];
                  end
               end
            end
            S_HOLD: begin
               if (tick) begin
                  if (hold_cnt_q == 8'd0) state_d = S_DOWN;
                  else                    hold_cnt_d = hold_cnt_q - 8'd1;
               end
            end
            S_DOWN: begin
               if (tick) begin
                  pend_d = 1'b1;
                  if (duty_q <= {4'b0, step_s_q}) begin
                     duty_d = 8'd0;
                     if (loop) begin
                        state_d = S_UP;
                     end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     duty_d = duty_q - {4'b0, step_s_q};
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
         // Abort overrides any tick or natural completion in the same cycle.
         if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            duty_d  = 8'd0;
            pend_d  = 1'b1;
            presc_d = '0;
            done_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         duty_q     <= 8'd0;
         pend_q     <= 1'b0;
         hold_cnt_q <= 8'd0;
         presc_q    <= '0;
         step_s_q   <= 4'd0;
         hold_s_q   <= 8'd0;
         div_s_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         pend_q     <= pend_d;
         hold_cnt_q <= hold_cnt_d;
         presc_q    <= presc_d;
         step_s_q   <= step_s_d;
         hold_s_q   <= hold_s_d;
         div_s_q    <= div_s_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: a ramp model lists the expected duty writes and the
// cycle each one lands in; directed steps cover collision, abort, loop, enable and reset.
module tb_pwm_ramp_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        host_we;
   logic [7:0]  host_wdata;
   logic        start;
   logic        stop;
   logic        loop;
   logic [3:0]  step;
   logic [7:0]  hold_ticks;
   logic [15:0] tick_div;
   logic        reg_we;
   logic [7:0]  reg_wdata;
   logic        busy;
   logic [1:0]  state;
   logic        done;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  exp_q[$];
   int          exp_t[$];
   int          done_off;

   pwm_ramp_sequencer #(.PRESC_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .host_we    (host_we),
      .host_wdata (host_wdata),
      .start      (start),
      .stop       (stop),
      .loop       (loop),
      .step       (step),
      .hold_ticks (hold_ticks),
      .tick_div   (tick_div),
      .reg_we     (reg_we),
      .reg_wdata  (reg_wdata),
      .busy       (busy),
      .state      (state),
      .done       (done)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected writes of one non-looping ramp: value and cycle offset, where
   // offset 0 is the first cycle after the edge that accepts start.
   task automatic build_model(input int st_in, input int hd, input int dv);
      int st   = (st_in == 0) ? 1 : st_in;
      int per  = dv + 1;
      int duty = 0;
      int k    = 0;
      exp_q.delete();
      exp_t.delete();
      exp_q.push_back(8'd0);
      exp_t.push_back(0);
      while (duty < 255) begin
         duty = (duty + st >= 255) ? 255 : duty + st;
         exp_q.push_back(8'(duty));
         exp_t.push_back(dv + k * per + 1);
         k++;
      end
      k += hd + 1;
      while (duty > 0) begin
         duty = (duty <= st) ? 0 : duty - st;
         exp_q.push_back(8'(duty));
         exp_t.push_back(dv + k * per + 1);
         k++;
      end
      done_off = exp_t[$];
   endtask

   // Runs a full ramp against the model; frz >= 0 drops ena for 5 cycles there.
   task automatic run_ramp(input int st, input int hd, input int dv, input int frz);
      logic we_e;
      build_model(st, hd, dv);
      @(negedge clk);
      step       = 4'(st);
      hold_ticks = 8'(hd);
      tick_div   = 16'(dv);
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      step       = 4'($urandom);
      hold_ticks = 8'($urandom);
      tick_div   = 16'($urandom_range(0, 7));
      for (int eff = 0; eff <= done_off + 1; eff++) begin
         if (eff == frz) begin
            for (int i = 0; i < 5; i++) begin
               ena        = 1'b0;
               host_we    = 1'b1;
               host_wdata = 8'($urandom);
               #1;
               chk("frz_we", reg_we, 1'b0);
               chk("frz_busy", busy, 1'b1);
               @(negedge clk);
            end
            ena     = 1'b1;
            host_we = 1'b0;
         end
         #1;
         we_e = (exp_t.size() > 0) && (exp_t[0] == eff);
         chk("ramp_we", reg_we, we_e);
         if (we_e) begin
            chk("ramp_wdata", reg_wdata, exp_q[0]);
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
         end
         chk("ramp_done", done, eff == done_off);
         chk("ramp_busy", busy, eff < done_off);
         @(negedge clk);
      end
      chk("ramp_all_writes_seen", exp_q.size(), 0);
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget);
      int n = 0;
      while (state !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_state", state, s);
   endtask

   initial begin
      int r_st, r_hd, r_dv, r_fz, n;
      rst_n = 1'b0; ena = 1'b1; host_we = 1'b0; host_wdata = 8'd0;
      start = 1'b0; stop = 1'b0; loop = 1'b0;
      step = 4'd0; hold_ticks = 8'd0; tick_div = 16'd0;

      // reset values, host path stays combinational during reset
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_state", state, 2'd0);
      chk("rst_done", done, 1'b0);
      chk("rst_we", reg_we, 1'b0);
      chk("rst_wdata", reg_wdata, 8'd0);
      host_we = 1'b1; host_wdata = 8'h5A; #1;
      chk("rst_host_we", reg_we, 1'b1);
      chk("rst_host_wdata", reg_wdata, 8'h5A);
      ena = 1'b0; #1;
      chk("rst_host_blocked", reg_we, 1'b0);
      ena = 1'b1; host_we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // full ramp, coarse ramp, ena freeze mid-UP
      run_ramp(0, 0, 0, -1);
      run_ramp(8, 2, 3, -1);
      run_ramp(4, 0, 2, 10);

      // random ramps
      for (int it = 0; it < 4; it++) begin
         r_st = $urandom_range(0, 15);
         r_hd = $urandom_range(0, 4);
         r_dv = $urandom_range(0, 3);
         r_fz = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : -1;
         run_ramp(r_st, r_hd, r_dv, r_fz);
      end

      // collision and coalescing (step 8, tick every 2 cycles at offsets 1,3,5,7)
      @(negedge clk);
      step = 4'd8; tick_div = 16'd1; hold_ticks = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; host_we = 1'b1; host_wdata = 8'hA5; #1;
      chk("col_we0", reg_we, 1'b1);
      chk("col_wdata0", reg_wdata, 8'hA5);
      @(negedge clk);
      host_we = 1'b0; #1;
      chk("col_deferred_we", reg_we, 1'b1);
      chk("col_deferred_wdata", reg_wdata, 8'd0);
      @(negedge clk);
      host_we = 1'b1; host_wdata = 8'h3C; #1;
      chk("col_host2", reg_wdata, 8'h3C);
      @(negedge clk);
      host_wdata = 8'hC3; #1;
      chk("col_host3_we", reg_we, 1'b1);
      chk("col_host3", reg_wdata, 8'hC3);
      @(negedge clk);
      host_wdata = 8'h7E; #1;
      chk("col_host4", reg_wdata, 8'h7E);
      @(negedge clk);
      host_we = 1'b0; #1;
      chk("col_coalesced_we", reg_we, 1'b1);
      chk("col_coalesced_wdata", reg_wdata, 8'd16);
      @(negedge clk); #1;
      chk("col_next_we", reg_we, 1'b1);
      chk("col_next_wdata", reg_wdata, 8'd24);
      @(negedge clk); #1;
      chk("col_idle_we", reg_we, 1'b0);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0; #1;
      chk("col_stop_state", state, 2'd0);
      chk("col_stop_we", reg_we, 1'b1);
      chk("col_stop_wdata", reg_wdata, 8'd0);
      chk("col_stop_done", done, 1'b0);
      @(negedge clk); #1;
      chk("col_stop_single", reg_we, 1'b0);

      // abort during HOLD
      @(negedge clk);
      step = 4'd15; tick_div = 16'd0; hold_ticks = 8'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_state(2'd2, 64);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0; #1;
      chk("abort_state", state, 2'd0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_we", reg_we, 1'b1);
      chk("abort_wdata", reg_wdata, 8'd0);
      chk("abort_done", done, 1'b0);
      @(negedge clk); #1;
      chk("abort_done_after", done, 1'b0);
      chk("abort_single_write", reg_we, 1'b0);

      // start and stop together in IDLE
      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; #1;
      chk("ss_state", state, 2'd0);
      chk("ss_busy", busy, 1'b0);
      chk("ss_we", reg_we, 1'b0);

      // loop: DOWN reaching 0 restarts UP without done
      @(negedge clk);
      step = 4'd15; tick_div = 16'd0; hold_ticks = 8'd0; loop = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_state(2'd3, 64);
      n = 0;
      while (state !== 2'd1 && n < 64) begin
         chk("loop_no_done", done, 1'b0);
         @(negedge clk);
         n++;
      end
      #1;
      chk("loop_restart_state", state, 2'd1);
      chk("loop_restart_done", done, 1'b0);
      chk("loop_restart_we", reg_we, 1'b1);
      chk("loop_restart_wdata", reg_wdata, 8'd0);
      @(negedge clk); #1;
      chk("loop_first_up_wdata", reg_wdata, 8'd15);
      loop = 1'b0; stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      @(negedge clk);

      // asynchronous reset mid-DOWN, then a fresh ramp from 0
      step = 4'd0; tick_div = 16'd0; hold_ticks = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_state(2'd3, 600);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0; #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_state", state, 2'd0);
      chk("arst_done", done, 1'b0);
      chk("arst_we", reg_we, 1'b0);
      chk("arst_wdata", reg_wdata, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_ramp(3, 1, 1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
